apb_mem_slave_ctrl: RTL and testbench

//  APB3 completer front-end for the byte-serial slave memory. Decodes APB setup/access phases and

---
 rtl/apb_mem_pkg.sv | 27 ++
 rtl/apb_mem_slave_ctrl_if.sv | 31 +++
 rtl/apb_mem_wdog.sv | 42 ++++
 rtl/apb_mem_slave_ctrl.sv | 154 +++++++++++++++
 tb/tb_apb_mem_slave_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory completer front-end.
//   state_e        : controller FSM states
//   NB             : byte lanes of the default 32-bit data path
//   addr_in_range  : true when a whole NB-byte access fits below end_addr
package apb_mem_pkg;

  localparam int unsigned APB_ADDR_SIZE = 32;
  localparam int unsigned APB_DATA_SIZE = 32;
  localparam int unsigned NB            = APB_DATA_SIZE / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Sum is formed one bit wider than the operands so the last byte address never wraps.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] nb,
                                         input logic [63:0] end_addr);
    logic [64:0] last;
    last = {1'b0, addr} + {1'b0, nb} - 65'd1;
    return (last <= {1'b0, end_addr});
  endfunction

endpackage

// File: rtl/apb_mem_slave_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and the memory front-end (slave).
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB : requester -> completer
//   PRDATA/PREADY/PSLVERR                  : completer -> requester
interface apb_mem_slave_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32
) ();

  localparam int unsigned STRB_W = DATA_SIZE / 8;

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDR_SIZE-1:0] PADDR;
  logic [DATA_SIZE-1:0] PWDATA;
  logic [STRB_W-1:0]    PSTRB;
  logic [DATA_SIZE-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_wdog.sv
// Wait-state watchdog for the memory front-end (built only with APB_MEM_TIMEOUT_EN).
//   PCLK/PRESETn : clock, async active-low reset
//   clear        : return count to zero
//   en           : count one cycle
//   expired_c    : en is high on the TIMEOUT_CYCLES-th counted cycle
`ifdef APB_MEM_TIMEOUT_EN
module apb_mem_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_c = en && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter saturates at the expiry value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !expired_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/apb_mem_slave_ctrl.sv
// APB3 completer front-end for the byte-serial slave memory.
// Turns each APB transfer into one write_init/read_init pulse, holds PREADY low until the
// memory reports completion, then returns PRDATA/PSLVERR for a single access cycle.
// Ports:
//   PCLK, PRESETn           : clock, async active-low reset
//   apb (slave modport)     : APB3 bus (PSEL..PSTRB in, PRDATA/PREADY/PSLVERR out)
//   mem_addr/wdata/strb     : latched request to memory (strobe zero on reads)
//   mem_rdata               : memory read data, valid with read_finished
//   write_init/read_init    : one-cycle request pulses
//   write_finished/read_finished : one-cycle completion pulses from memory
// Build option: APB_MEM_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on the WAIT state.
module apb_mem_slave_ctrl
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = APB_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = APB_DATA_SIZE,
  parameter int unsigned END_ADDR  = 4095
`ifdef APB_MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  apb_mem_slave_ctrl_if.slave    apb,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic [DATA_SIZE-1:0]   mem_wdata,
  output logic [DATA_SIZE/8-1:0] mem_strb,
  input  logic [DATA_SIZE-1:0]   mem_rdata,
  output logic                   write_init,
  input  logic                   write_finished,
  output logic                   read_init,
  input  logic                   read_finished
);

  localparam int unsigned NB_LANES = DATA_SIZE / 8;

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NB_LANES-1:0]   mem_strb_q, mem_strb_d;
  logic                  write_init_q, write_init_d;
  logic                  read_init_q, read_init_d;
  logic [DATA_SIZE-1:0]  prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  in_range_c;
  logic                  timeout_c;

  assign in_range_c = addr_in_range(64'(apb.PADDR), 64'(NB_LANES), 64'(END_ADDR));

`ifdef APB_MEM_TIMEOUT_EN
  // Counts only while waiting; any other state rearms it.
  apb_mem_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clear     (state_q != ST_WAIT),
    .en        (state_q == ST_WAIT),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and output logic; response data/error live only for the RESP cycle.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_strb_d   = mem_strb_q;
    write_init_d = 1'b0;
    read_init_d  = 1'b0;
    prdata_d     = '0;
    pslverr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          is_write_d  = apb.PWRITE;
          mem_addr_d  = apb.PADDR;
          mem_wdata_d = apb.PWDATA;
          mem_strb_d  = apb.PWRITE ? apb.PSTRB : '0;
          if (in_range_c) begin
            state_d      = ST_REQ;
            write_init_d = apb.PWRITE;
            read_init_d  = !apb.PWRITE;
          end else begin
            state_d   = ST_RESP;
            pslverr_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion of the other type is not ours and is ignored.
        if (is_write_q && write_finished) begin
          state_d = ST_RESP;
        end else if (!is_write_q && read_finished) begin
          state_d  = ST_RESP;
          prdata_d = mem_rdata;
        end else if (timeout_c) begin
          state_d   = ST_RESP;
          pslverr_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      is_write_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_strb_q   <= '0;
      write_init_q <= 1'b0;
      read_init_q  <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_strb_q   <= mem_strb_d;
      write_init_q <= write_init_d;
      read_init_q  <= read_init_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
    end
  end

  // PREADY is qualified by the live access phase so an aborted transfer sees no pulse.
  assign apb.PREADY  = (state_q == ST_RESP) && apb.PSEL && apb.PENABLE;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_strb   = mem_strb_q;
  assign write_init = write_init_q;
  assign read_init  = read_init_q;

endmodule

// File: tb/tb_apb_mem_slave_ctrl.sv
// Directed bench for apb_mem_slave_ctrl paired with a behavioural byte-serial memory.
module tb_apb_mem_slave_ctrl;
  import apb_mem_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [NB-1:0] mem_strb;
  logic        write_init, write_finished, read_init, read_finished;

  apb_mem_slave_ctrl_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) apb ();

  apb_mem_slave_ctrl dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .apb            (apb),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_strb       (mem_strb),
    .mem_rdata      (mem_rdata),
    .write_init     (write_init),
    .write_finished (write_finished),
    .read_init      (read_init),
    .read_finished  (read_finished)
  );

  always #5 PCLK = ~PCLK;

  // Memory model: latency in idle cycles after the request, optional read-done suppression.
  logic [7:0] mem [0:4095];
  int         mem_lat = 0;
  logic       suppress_rd = 1'b0;
  logic       wr_pend, rd_pend;
  int         cnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_pend <= 1'b0; rd_pend <= 1'b0; cnt <= 0;
      write_finished <= 1'b0; read_finished <= 1'b0; mem_rdata <= '0;
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else begin
      write_finished <= 1'b0;
      read_finished  <= 1'b0;
      if (write_init) begin
        wr_pend <= 1'b1; cnt <= mem_lat;
      end else if (read_init) begin
        rd_pend <= 1'b1; cnt <= mem_lat;
      end else if (wr_pend) begin
        if (cnt == 0) begin
          wr_pend <= 1'b0; write_finished <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (mem_strb[b]) mem[int'(mem_addr[11:0]) + b] <= mem_wdata[8*b +: 8];
        end else cnt <= cnt - 1;
      end else if (rd_pend) begin
        if (cnt == 0) begin
          rd_pend <= 1'b0;
          if (!suppress_rd) begin
            read_finished <= 1'b1;
            mem_rdata <= {mem[int'(mem_addr[11:0]) + 3], mem[int'(mem_addr[11:0]) + 2],
                          mem[int'(mem_addr[11:0]) + 1], mem[int'(mem_addr[11:0])]};
          end
        end else cnt <= cnt - 1;
      end
    end
  end

  // Bus monitor: request pulses and PREADY pulse widths.
  int n_init = 0, n_both = 0, n_pready = 0, run = 0, max_run = 0;
  always @(negedge PCLK) begin
    n_init += int'(write_init) + int'(read_init);
    if (write_init && read_init) n_both++;
    if (apb.PREADY) begin
      n_pready++; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  end

  int checks = 0, passed = 0, failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the transfer.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int waits);
    logic got;
    got = 1'b0; waits = 0; rdata = '0; err = 1'b0;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = addr; apb.PWDATA = wdata; apb.PSTRB = strb;
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (apb.PREADY) begin
        got = 1'b1; rdata = apb.PRDATA; err = apb.PSLVERR;
        break;
      end
      waits++;
    end
    chk("pready_seen", 32'(got), 32'd1);
    @(posedge PCLK); #1;
  endtask

  task automatic bus_idle();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt, i0, p0;

  initial begin
    PRESETn = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready",  32'(apb.PREADY),  32'd0);
    chk("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
    chk("rst_prdata",  apb.PRDATA,       32'd0);
    chk("rst_inits",   32'({write_init, read_init}), 32'd0);
    chk("rst_mem_strb", 32'(mem_strb),   32'd0);
    chk("rst_mem_addr", mem_addr,        32'd0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Full-word write then read back.
    mem_lat = 1;
    xfer(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, rd, er, wt);
    chk("wr10_err", 32'(er), 32'd0);
    chk("wr10_prdata", rd, 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
    chk("rd10_data", rd, 32'hA5A5_1234);
    chk("rd10_err", 32'(er), 32'd0);

    // Partial strobes over zeroed memory.
    bus_idle();
    xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0101, rd, er, wt);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, wt);
    chk("rd20_strb", rd, 32'h00FF_00FF);

    // Last fully in-range word.
    xfer(1'b1, 32'd4092, 32'hDEAD_BEEF, 4'hF, rd, er, wt);
    chk("wr4092_err", 32'(er), 32'd0);
    xfer(1'b0, 32'd4092, 32'h0, 4'h0, rd, er, wt);
    chk("rd4092_data", rd, 32'hDEAD_BEEF);

    // Out of range: immediate error, no memory request.
    bus_idle();
    i0 = n_init;
    xfer(1'b0, 32'd4094, 32'h0, 4'h0, rd, er, wt);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_waits", 32'(wt), 32'd0);
    chk("oor_rd_data", rd, 32'd0);
    xfer(1'b1, 32'd4094, 32'h1234_5678, 4'hF, rd, er, wt);
    chk("oor_wr_err", 32'(er), 32'd1);
    xfer(1'b1, 32'hFFFF_FFFE, 32'h1, 4'hF, rd, er, wt);
    chk("oor_wrap_err", 32'(er), 32'd1);
    chk("oor_no_init", 32'(n_init - i0), 32'd0);

    // Zero-strobe write still requests, returns OKAY, leaves data untouched.
    i0 = n_init;
    xfer(1'b1, 32'h10, 32'h0000_0000, 4'h0, rd, er, wt);
    chk("strb0_err", 32'(er), 32'd0);
    chk("strb0_init", 32'(n_init - i0), 32'd1);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
    chk("strb0_keep", rd, 32'hA5A5_1234);

    // Back-to-back write/read/write with no idle gap.
    bus_idle();
    i0 = n_init; p0 = n_pready;
    xfer(1'b1, 32'h40, 32'h1122_3344, 4'hF, rd, er, wt);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, wt);
    chk("b2b_rd", rd, 32'h1122_3344);
    xfer(1'b1, 32'h44, 32'h5566_7788, 4'hF, rd, er, wt);
    bus_idle();
    chk("b2b_inits", 32'(n_init - i0), 32'd3);
    chk("b2b_preadys", 32'(n_pready - p0), 32'd3);

    // Requester abandons a read in WAIT; no PREADY, then normal service resumes.
    mem_lat = 5;
    p0 = n_pready;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h44;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("req_read_init", 32'({write_init, read_init}), 32'b01);
    chk("req_read_strb", 32'(mem_strb), 32'd0);
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    repeat (15) @(posedge PCLK);
    #1;
    chk("abort_no_pready", 32'(n_pready - p0), 32'd0);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, rd, er, wt);
    chk("after_abort_rd", rd, 32'h5566_7788);

    // Reset while waiting on the memory.
    bus_idle();
    mem_lat = 10;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h40;
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(apb.PREADY), 32'd0);
    chk("mid_rst_inits", 32'({write_init, read_init}), 32'd0);
    chk("mid_rst_pslverr", 32'(apb.PSLVERR), 32'd0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    mem_lat = 2;
    xfer(1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, rd, er, wt);
    chk("post_rst_wr_err", 32'(er), 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
    chk("post_rst_rd", rd, 32'hCAFE_F00D);

`ifdef APB_MEM_TIMEOUT_EN
    // Memory never answers: REQ cycle plus 64 WAIT cycles, then an error response.
    bus_idle();
    mem_lat = 0;
    suppress_rd = 1'b1;
    xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_data", rd, 32'd0);
    chk("tmo_waits", 32'(wt), 32'd65);
    suppress_rd = 1'b0;
    xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
    chk("tmo_recover", rd, 32'hCAFE_F00D);
`endif

    bus_idle();
    chk("pready_single", 32'(max_run), 32'd1);
    chk("inits_exclusive", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
